ir_dram_loader: RTL and testbench
=================================

// Module: ir_dram_loader
// PURPOSE
//   Sequences diagnostic loading/readback of the 512x15 dispatch RAM (DRAM) on the
//   IR board. Arbitrates the single DRAM address/write port between the EBOX
//   dispatch path (LOAD_DRAM strobe, absolute priority) and a diagnostic
//   request stream. Writes are verified by readback with bounded retry.
// PARAMETERS
//   ADDR_BITS  9   DRAM address width (512 words)
//   DATA_BITS  15  DRAM word width
//   MAX_RETRY  2   extra write+verify attempts after first mismatch (0..7)
// PORTS
//   clk           in   1          IR clock; all state changes on posedge
//   reset         in   1          asynchronous, active-high
//   diag_en       in   1          EBOX stopped; loader may own DRAM port
//   ir_load_dram  in   1          EBOX dispatch load this cycle; preempts loader
//   ir_dradr      in   ADDR_BITS  EBOX dispatch address
//   req_valid     in   1          diagnostic request present
//   req_ready     out  1          request accepted when valid&ready
//   req_write     in   1          1=write+verify, 0=readback
//   req_addr      in   ADDR_BITS  target DRAM address
//   req_data      in   DATA_BITS  write data
//   dram_addr     out  ADDR_BITS  to DRAM addra
//   dram_din      out  DATA_BITS  to DRAM dina
//   dram_wea      out  1          DRAM write enable
//   dram_dout     in   DATA_BITS  DRAM read data, 1-cycle latency
//   rsp_valid     out  1          one-cycle response pulse
//   rsp_data      out  DATA_BITS  readback word (last read)
//   rsp_err       out  2          00 ok, 01 verify fail, 10 aborted
//   rsp_par       out  1          odd parity of rsp_data (XOR reduce)
//   busy          out  1          state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=0, dram_wea=0, rsp_valid=0, rsp_data=0,
//     rsp_err=0, rsp_par=0, busy=0, retry count=0; dram_addr follows mux.
//   Port mux (combinational): ir_load_dram=1 -> dram_addr=ir_dradr, dram_wea=0,
//     loader "stalled" this cycle. Else dram_addr=latched loader address.
//   req_ready = (state==IDLE) & diag_en & ~ir_load_dram. Accept latches addr,
//     data, write flag; retry count cleared.
//   States (advance only in non-stalled cycles unless noted):
//     IDLE  -> WR on accept with write=1; -> RD on accept with write=0.
//     WR    : dram_wea=1, dram_din=latched data, one cycle -> VRD.
//     VRD   : issue read of latched addr -> CMP.
//     CMP   : sample dram_dout (from VRD cycle; valid even if this cycle stalled)
//             into rsp_data. Equal -> RSP err=00. Unequal & retries<MAX_RETRY
//             -> retries+1, WR. Unequal & exhausted -> RSP err=01.
//     RD    : issue read -> RCAP.  RCAP: capture dram_dout, -> RSP err=00.
//     RSP   : rsp_valid=1 exactly one cycle (not gated by stall) -> IDLE.
//   Stall in WR/VRD/RD: no loader memory action, state held, action reissued
//     next unstalled cycle. Total latency unstalled: write 4 cycles accept->rsp
//     per attempt path (WR,VRD,CMP,RSP); read 3 (RD,RCAP,RSP).
//   diag_en falling in WR/VRD/CMP/RD/RCAP: wea forced 0 that cycle, -> RSP
//     err=10, rsp_data unchanged. IDLE unaffected.
//   Reset mid-operation: immediate return to reset values; no partial response.
//   rsp_par recomputed whenever rsp_data loads. No back-to-back accept: next
//     accept earliest cycle after RSP.
// TESTING
//   Write 0o12345 @0o254, no stall -> wea 1 cycle, rsp_valid at cycle 4,
//     rsp_err=00, rsp_data=0o12345, rsp_par=^0o12345.
//   Read @0o777 preloaded 0o7070 -> rsp 3 cycles after accept, data=0o7070.
//   ir_load_dram held 3 cycles during WR -> dram_addr=ir_dradr, wea=0 those
//     cycles; write completes after stall, rsp_err=00, latency +3.
//   Model forcing dout bit0 stuck, MAX_RETRY=2 -> 3 write pulses, rsp_err=01.
//   diag_en drops in VRD -> next cycle rsp_valid, rsp_err=10; req_ready=0 until
//     diag_en returns. Reset asserted in CMP -> busy=0, no rsp_valid.

Source files
------------

// File: rtl/ir_dram_loader.sv
// ---------------------------------------------------------------------------
// ir_dram_loader
//
// Diagnostic loader/readback sequencer for the 512x15 dispatch RAM (DRAM) on
// the IR board. The DRAM has a single address/write port, shared between the
// EBOX dispatch path and this loader. The EBOX always wins: whenever
// ir_load_dram is high, the port carries ir_dradr, the loader's write is
// suppressed, and the loader treats that cycle as a stall.
//
// A diagnostic write is verified by reading the word back. On a mismatch the
// loader retries the write+verify up to MAX_RETRY more times. A diagnostic
// read simply returns the stored word.
//
// Ports
//   clk           IR clock, all state changes on the rising edge
//   reset         asynchronous, active-high
//   diag_en       EBOX stopped; the loader may own the DRAM port
//   ir_load_dram  EBOX dispatch load this cycle (preempts the loader)
//   ir_dradr      EBOX dispatch address
//   req_valid     diagnostic request present
//   req_ready     request accepted when req_valid & req_ready
//   req_write     1 = write+verify, 0 = readback
//   req_addr      target DRAM address
//   req_data      write data
//   dram_addr     DRAM address (muxed between EBOX and loader)
//   dram_din      DRAM write data
//   dram_wea      DRAM write enable
//   dram_dout     DRAM read data, one cycle after the address
//   rsp_valid     one-cycle response pulse
//   rsp_data      last word read back
//   rsp_err       00 ok, 01 verify failed, 10 aborted
//   rsp_par       odd parity of rsp_data (XOR reduction)
//   busy          sequencer not idle
// ---------------------------------------------------------------------------
module ir_dram_loader #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 15,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 diag_en,
    input  logic                 ir_load_dram,
    input  logic [ADDR_BITS-1:0] ir_dradr,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_data,
    output logic [ADDR_BITS-1:0] dram_addr,
    output logic [DATA_BITS-1:0] dram_din,
    output logic                 dram_wea,
    input  logic [DATA_BITS-1:0] dram_dout,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [1:0]           rsp_err,
    output logic                 rsp_par,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_VRD  = 3'd2,
        S_CMP  = 3'd3,
        S_RD   = 3'd4,
        S_RCAP = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_VERIFY = 2'b01;
    localparam logic [1:0] ERR_ABORT  = 2'b10;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [2:0]             retry_q, retry_d;
    logic [DATA_BITS-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]             rsp_err_q, rsp_err_d;
    logic                   rsp_par_q, rsp_par_d;

    logic                   stall;
    logic                   in_op;
    logic                   abort;
    logic                   wea;
    logic                   ready;

    // The EBOX owns the port in any cycle it loads the DRAM.
    assign stall = ir_load_dram;

    // Loss of diag_en only matters while an operation is in flight;
    // IDLE and RSP are unaffected.
    assign in_op = (state_q == S_WR)  || (state_q == S_VRD) ||
                   (state_q == S_CMP) || (state_q == S_RD)  ||
                   (state_q == S_RCAP);
    assign abort = in_op && !diag_en;

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        retry_d    = retry_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        wea        = 1'b0;
        ready      = 1'b0;

        if (abort) begin
            // Write enable stays low this cycle and the last readback word
            // is reported unchanged.
            rsp_err_d = ERR_ABORT;
            state_d   = S_RSP;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready = diag_en && !stall;
                    if (req_valid && ready) begin
                        addr_d  = req_addr;
                        data_d  = req_data;
                        retry_d = 3'd0;
                        state_d = req_write ? S_WR : S_RD;
                    end
                end

                S_WR: begin
                    if (!stall) begin
                        wea     = 1'b1;
                        state_d = S_VRD;
                    end
                end

                S_VRD: begin
                    if (!stall) begin
                        state_d = S_CMP;
                    end
                end

                // dram_dout here is the word addressed during VRD, so it is
                // usable even if the EBOX has taken the port this cycle.
                S_CMP: begin
                    rsp_data_d = dram_dout;
                    if (dram_dout == data_q) begin
                        rsp_err_d = ERR_OK;
                        state_d   = S_RSP;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_WR;
                    end else begin
                        rsp_err_d = ERR_VERIFY;
                        state_d   = S_RSP;
                    end
                end

                S_RD: begin
                    if (!stall) begin
                        state_d = S_RCAP;
                    end
                end

                S_RCAP: begin
                    rsp_data_d = dram_dout;
                    rsp_err_d  = ERR_OK;
                    state_d    = S_RSP;
                end

                // Response pulse is never held off by a stall.
                S_RSP: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Parity tracks whatever is loaded into rsp_data.
    assign rsp_par_d = ^rsp_data_d;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            retry_q    <= 3'd0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
            rsp_par_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            retry_q    <= retry_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            rsp_par_q  <= rsp_par_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dram_addr = stall ? ir_dradr : addr_q;
    assign dram_din  = data_q;
    assign dram_wea  = wea;
    assign req_ready = ready;
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_par   = rsp_par_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_dram_loader.sv
module tb_ir_dram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        diag_en;
    logic        ir_load_dram;
    logic [8:0]  ir_dradr;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [14:0] req_data;
    logic [8:0]  dram_addr;
    logic [14:0] dram_din;
    logic        dram_wea;
    logic [14:0] dram_dout;
    logic        rsp_valid;
    logic [14:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        rsp_par;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [14:0] data;
        logic [1:0]  err;
    } exp_t;
    exp_t exp_q[$];

    logic [14:0] last_data = 15'd0;

    always #5 clk = ~clk;

    ir_dram_loader #(.ADDR_BITS(9), .DATA_BITS(15), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .diag_en(diag_en),
        .ir_load_dram(ir_load_dram), .ir_dradr(ir_dradr),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .dram_addr(dram_addr), .dram_din(dram_din), .dram_wea(dram_wea),
        .dram_dout(dram_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rsp_par(rsp_par), .busy(busy)
    );

    // DRAM model: synchronous read-first RAM with optional bit0 stuck-at-0.
    logic [14:0] mem [0:511];
    logic [14:0] dout_q = 15'd0;
    logic        stuck0 = 1'b0;
    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = 9'd0;
    logic [14:0] pl_data = 15'd0;
    int          wea_total = 0;
    int          stall_bad = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (dram_wea) mem[dram_addr] <= dram_din;
        dout_q <= mem[dram_addr];
        if (dram_wea) wea_total <= wea_total + 1;
        if (ir_load_dram && (dram_wea || dram_addr !== ir_dradr)) stall_bad <= stall_bad + 1;
    end
    assign dram_dout = stuck0 ? (dout_q & 15'h7FFE) : dout_q;

    task automatic preload(input logic [8:0] a, input logic [14:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Presents one request for a single edge; returns one cycle after accept.
    task automatic issue(input logic wr, input logic [8:0] a, input logic [14:0] d);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Waits for rsp_valid; lat = cycles since accept, -1 on timeout.
    task automatic wait_rsp(input int start, output int lat);
        lat = -1;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid === 1'b1) begin
                lat = start + c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; diag_en = 1'b0; ir_load_dram = 1'b1; ir_dradr = 9'o555;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 9'd0; req_data = 15'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, dram_wea, rsp_valid, busy, rsp_par} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b wea=%b vld=%b busy=%b par=%b want all 0",
                     req_ready, dram_wea, rsp_valid, busy, rsp_par);
        end
        checks++;
        if (rsp_data !== 15'd0 || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp got data=%o err=%b want 0 00", rsp_data, rsp_err);
        end
        checks++;
        if (dram_addr !== 9'o555) begin
            errors++;
            $display("FAIL reset_mux got %o want 555", dram_addr);
        end
        ir_load_dram = 1'b0;
        reset = 1'b0;
        diag_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_write;
        int lat, w0;
        exp_t e;
        exp_q.push_back('{data: 15'o12345, err: 2'b00});
        w0 = wea_total;
        issue(1'b1, 9'o254, 15'o12345);
        wait_rsp(1, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL write_latency got %0d want 4", lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_data !== e.data || rsp_err !== e.err || rsp_par !== ^e.data) begin
            errors++;
            $display("FAIL write_rsp got %o/%b/%b want %o/%b/%b",
                     rsp_data, rsp_err, rsp_par, e.data, e.err, ^e.data);
        end
        last_data = e.data;
        checks++;
        if (wea_total - w0 != 1 || mem[9'o254] !== 15'o12345) begin
            errors++;
            $display("FAIL write_pulses got %0d mem=%o want 1 12345", wea_total - w0, mem[9'o254]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read;
        int lat;
        exp_t e;
        preload(9'o777, 15'o07070);
        exp_q.push_back('{data: 15'o07070, err: 2'b00});
        issue(1'b0, 9'o777, 15'd0);
        wait_rsp(1, lat);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL read_latency got %0d want 3", lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_data !== e.data || rsp_err !== e.err || rsp_par !== ^e.data) begin
            errors++;
            $display("FAIL read_rsp got %o/%b/%b want %o/%b/%b",
                     rsp_data, rsp_err, rsp_par, e.data, e.err, ^e.data);
        end
        last_data = e.data;
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int lat, w0, s0;
        exp_t e;
        bit bad;
        exp_q.push_back('{data: 15'o54321, err: 2'b00});
        w0 = wea_total;
        s0 = stall_bad;
        issue(1'b1, 9'o100, 15'o54321);
        bad = 1'b0;
        ir_load_dram = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ir_dradr = 9'o123 + 9'(i);
            #1;
            if (dram_addr !== ir_dradr || dram_wea !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
        end
        ir_load_dram = 1'b0;
        checks++;
        if (bad || stall_bad != s0) begin
            errors++;
            $display("FAIL stall_port got bad=%b viol=%0d want 0 0", bad, stall_bad - s0);
        end
        wait_rsp(4, lat);
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL stall_latency got %0d want 7", lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_data !== e.data || rsp_err !== e.err || wea_total - w0 != 1 || mem[9'o100] !== e.data) begin
            errors++;
            $display("FAIL stall_rsp got %o/%b pulses=%0d mem=%o want %o/%b 1",
                     rsp_data, rsp_err, wea_total - w0, mem[9'o100], e.data, e.err);
        end
        last_data = e.data;
        @(posedge clk); #1;
    endtask

    task automatic test_retry;
        int lat, w0;
        exp_t e;
        stuck0 = 1'b1;
        exp_q.push_back('{data: 15'o12344, err: 2'b01});
        w0 = wea_total;
        issue(1'b1, 9'o005, 15'o12345);
        wait_rsp(1, lat);
        checks++;
        if (wea_total - w0 != 3 || lat != 10) begin
            errors++;
            $display("FAIL retry_pulses got %0d lat=%0d want 3 10", wea_total - w0, lat);
        end
        e = exp_q.pop_front();
        checks++;
        if (rsp_data !== e.data || rsp_err !== e.err || rsp_par !== ^e.data) begin
            errors++;
            $display("FAIL retry_rsp got %o/%b/%b want %o/%b/%b",
                     rsp_data, rsp_err, rsp_par, e.data, e.err, ^e.data);
        end
        last_data = e.data;
        stuck0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        exp_t e;
        exp_q.push_back('{data: last_data, err: 2'b10});
        issue(1'b1, 9'o300, 15'o11111);
        @(posedge clk); #1;               // now in VRD
        diag_en = 1'b0;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL abort_rsp got vld=%b %o/%b want 1 %o/%b",
                     rsp_valid, rsp_data, rsp_err, e.data, e.err);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready got rdy=%b busy=%b vld=%b want 0 0 0", req_ready, busy, rsp_valid);
        end
        req_valid = 1'b0;
        diag_en = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_recover got %b want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit seen;
        issue(1'b1, 9'o310, 15'o22222);
        @(posedge clk); #1;
        @(posedge clk); #1;               // now in CMP
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 15'd0 || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got busy=%b vld=%b %o/%b want 0 0 0/00", busy, rsp_valid, rsp_data, rsp_err);
        end
        seen = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_norsp got pulse want none");
        end
        last_data = 15'd0;
    endtask

    task automatic test_back_to_back;
        int lat;
        exp_t e;
        preload(9'o400, 15'o01234);
        preload(9'o401, 15'o04321);
        exp_q.push_back('{data: 15'o01234, err: 2'b00});
        exp_q.push_back('{data: 15'o04321, err: 2'b00});
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'o400;
        @(posedge clk); #1;
        req_addr = 9'o401;                // held valid for the next request
        wait_rsp(1, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 3 || rsp_data !== e.data || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d %o rdy=%b want 3 %o 0", lat, rsp_data, req_ready, e.data);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got rdy=%b busy=%b want 1 0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(1, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat != 3 || rsp_data !== e.data || rsp_par !== ^e.data) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d %o/%b want 3 %o/%b", lat, rsp_data, rsp_par, e.data, ^e.data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_retry();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
